memory_writeback: RTL and testbench

- Final core stage; consumes the decode/execute result bundle: opcode, func3, wb_reg, rd_num, rd_data (ALU result / effective address), rs2_data (store data).
- Non-memory results are registered and written to the regfile.
- Loads and stores run a data-memory transaction through a req/gnt/rvalid handshake.
- Stalls fetch while a transaction is in flight.

---
 rtl/memory_writeback.sv | 249 ++++++++++++++++++++++++
 tb/tb_memory_writeback.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_writeback.sv
// Final pipeline stage: registers ALU results into the regfile and runs
// load/store transactions on a req/gnt/rvalid data bus, stalling fetch meanwhile.
module memory_writeback #(
  parameter logic [6:0]  OP_LOAD     = 7'b0000011,
  parameter logic [6:0]  OP_STORE    = 7'b0100011,
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        wb_reg,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rd_data,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_wr_num,
  output logic [31:0] rf_wr_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(RSP_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_num_q, rf_num_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        mis_q, mis_d;
  logic        bus_err_q, bus_err_d;

  // Captured transaction
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic [4:0]  rd_q;

  logic        is_load, is_store, is_mem;
  logic        f3_legal, aligned, access_ok;
  logic        capture;
  logic        stall_c;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // ---------------- Decode of the incoming bundle ----------------
  assign is_load  = in_valid && (opcode == OP_LOAD);
  assign is_store = in_valid && (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;

  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      case (func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                 f3_legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (func3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
  end

  // func3[1:0] encodes the access size for every legal load/store
  always_comb begin
    case (func3[1:0])
      2'b01:   aligned = ~rd_data[0];
      2'b10:   aligned = (rd_data[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign access_ok = f3_legal && aligned;

  always_comb begin
    case (func3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << rd_data[1:0];
        wdata_calc = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << rd_data[1:0];
        wdata_calc = {2{rs2_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = rs2_data;
      end
    endcase
  end

  // ---------------- Load data extraction ----------------
  assign lane_shift = dmem_rdata >> {off_q, 3'b000};
  assign byte_sel   = lane_shift[7:0];
  assign half_sel   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (func3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // ---------------- Next-state / output logic ----------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rf_we_d   = 1'b0;
    rf_num_d  = rf_num_q;
    rf_data_d = rf_data_q;
    mis_d     = 1'b0;
    bus_err_d = 1'b0;
    capture   = 1'b0;
    stall_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          if (access_ok) begin
            capture = 1'b1;
            stall_c = 1'b1;
            state_d = S_REQ;
          end else begin
            mis_d = 1'b1;
          end
        end else begin
          rf_we_d   = in_valid && wb_reg && (rd_num != 5'd0);
          rf_num_d  = rd_num;
          rf_data_d = rd_data;
        end
      end

      S_REQ: begin
        stall_c = 1'b1;
        if (dmem_gnt) begin
          if (we_q) begin
            // Store retires at the grant edge
            stall_c = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (dmem_rvalid) begin
          rf_we_d   = (rd_q != 5'd0);
          rf_num_d  = rd_q;
          rf_data_d = load_data;
          state_d   = S_WB;
        end else if (cnt_q == TIMEOUT_LAST) begin
          bus_err_d = 1'b1;
          stall_c   = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- State and result registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      rf_we_q   <= 1'b0;
      rf_num_q  <= 5'd0;
      rf_data_q <= 32'd0;
      mis_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_we_q   <= rf_we_d;
      rf_num_q  <= rf_num_d;
      rf_data_q <= rf_data_d;
      mis_q     <= mis_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Bus-side capture; held stable through REQ until the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      off_q   <= 2'b00;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      func3_q <= 3'd0;
      rd_q    <= 5'd0;
    end else if (capture) begin
      we_q    <= is_store;
      addr_q  <= {rd_data[31:2], 2'b00};
      off_q   <= rd_data[1:0];
      be_q    <= be_calc;
      wdata_q <= wdata_calc;
      func3_q <= func3;
      rd_q    <= rd_num;
    end
  end

  // ---------------- Outputs ----------------
  assign stall        = stall_c && rst_n;
  assign dmem_req     = (state_q == S_REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign rf_we        = rf_we_q;
  assign rf_wr_num    = rf_num_q;
  assign rf_wr_data   = rf_data_q;
  assign misalign_err = mis_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: ALU writeback, store/load handshakes,
// misaligned/illegal drops, response timeout and asynchronous reset.
module tb_memory_writeback;

  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        wb_reg;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_wr_num;
  logic [31:0] rf_wr_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        misalign_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  memory_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .func3(func3), .wb_reg(wb_reg), .rd_num(rd_num), .rd_data(rd_data),
    .rs2_data(rs2_data), .stall(stall), .rf_we(rf_we), .rf_wr_num(rf_wr_num),
    .rf_wr_data(rf_wr_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp, input logic [3:0] exp_be);
    in_valid = 1'b1; opcode = OPL; func3 = f3; rd_data = addr; rd_num = rd; wb_reg = 1'b1;
    #2; chk("ld_issue_stall", 32'(stall), 32'd1); chk("ld_issue_req", 32'(dmem_req), 32'd0);
    cyc(); in_valid = 1'b0; dmem_gnt = 1'b1;
    #2; chk("ld_req", 32'(dmem_req), 32'd1); chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_addr", dmem_addr, {addr[31:2], 2'b00}); chk("ld_be", 32'(dmem_be), 32'(exp_be));
    chk("ld_gnt_stall", 32'(stall), 32'd1);
    cyc(); dmem_gnt = 1'b0;
    #2; chk("ld_wait_req", 32'(dmem_req), 32'd0); chk("ld_wait_stall", 32'(stall), 32'd1);
    chk("ld_wait_we", 32'(rf_we), 32'd0);
    cyc(); dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #2; chk("ld_rv_stall", 32'(stall), 32'd1); chk("ld_rv_we", 32'(rf_we), 32'd0);
    cyc(); dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #2; chk("ld_wb_we", 32'(rf_we), 32'd1); chk("ld_wb_num", 32'(rf_wr_num), 32'(rd));
    chk("ld_wb_data", rf_wr_data, exp); chk("ld_wb_stall", 32'(stall), 32'd0);
    cyc();
    #2; chk("ld_post_we", 32'(rf_we), 32'd0); chk("ld_post_stall", 32'(stall), 32'd0);
  endtask

  task automatic do_bad(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr);
    in_valid = 1'b1; opcode = op; func3 = f3; rd_data = addr; rd_num = 5'd4; wb_reg = 1'b1;
    #2; chk("bad_stall", 32'(stall), 32'd0); chk("bad_req", 32'(dmem_req), 32'd0);
    cyc(); in_valid = 1'b0;
    #2; chk("bad_mis", 32'(misalign_err), 32'd1); chk("bad_req2", 32'(dmem_req), 32'd0);
    chk("bad_rfwe", 32'(rf_we), 32'd0);
    cyc();
    #2; chk("bad_mis_end", 32'(misalign_err), 32'd0); chk("bad_req3", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = 7'd0; func3 = 3'd0; wb_reg = 1'b0;
    rd_num = 5'd0; rd_data = 32'd0; rs2_data = 32'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;

    // Reset state
    cyc(); cyc();
    #2; chk("rst_stall", 32'(stall), 32'd0); chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_rfwe", 32'(rf_we), 32'd0); chk("rst_mis", 32'(misalign_err), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0); chk("rst_addr", dmem_addr, 32'd0);
    cyc(); rst_n = 1'b1;

    // ALU result, then rd=0
    cyc(); in_valid = 1'b1; opcode = OPR; wb_reg = 1'b1; rd_num = 5'd5; rd_data = 32'h1234;
    #2; chk("alu_stall", 32'(stall), 32'd0);
    cyc(); rd_num = 5'd0; rd_data = 32'h5555;
    #2; chk("alu_we", 32'(rf_we), 32'd1); chk("alu_num", 32'(rf_wr_num), 32'd5);
    chk("alu_data", rf_wr_data, 32'h1234); chk("alu_stall2", 32'(stall), 32'd0);
    cyc(); in_valid = 1'b0;
    #2; chk("alu_x0_we", 32'(rf_we), 32'd0);

    // SB at 0x103, gnt low for 3 cycles
    cyc(); in_valid = 1'b1; opcode = OPS; func3 = 3'b000; wb_reg = 1'b0; rd_num = 5'd0;
    rd_data = 32'h103; rs2_data = 32'hAABBCCDD;
    #2; chk("sb_issue_stall", 32'(stall), 32'd1); chk("sb_issue_req", 32'(dmem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); in_valid = 1'b0; dmem_gnt = 1'b0;
      #2; chk("sb_req", 32'(dmem_req), 32'd1); chk("sb_stall", 32'(stall), 32'd1);
      chk("sb_addr", dmem_addr, 32'h100); chk("sb_be", 32'(dmem_be), 32'b1000);
      chk("sb_wdata", dmem_wdata, 32'hDDDDDDDD); chk("sb_we", 32'(dmem_we), 32'd1);
      chk("sb_rfwe", 32'(rf_we), 32'd0);
    end
    cyc(); dmem_gnt = 1'b1;
    #2; chk("sb_gnt_req", 32'(dmem_req), 32'd1); chk("sb_gnt_stall", 32'(stall), 32'd0);
    cyc(); dmem_gnt = 1'b0;
    #2; chk("sb_done_req", 32'(dmem_req), 32'd0); chk("sb_done_stall", 32'(stall), 32'd0);
    chk("sb_done_rfwe", 32'(rf_we), 32'd0);

    // Loads with lane selection and extension
    cyc();
    do_load(3'b000, 32'h202, 5'd7, 32'h00800000, 32'hFFFFFF80, 4'b0100);
    do_load(3'b100, 32'h202, 5'd8, 32'h00800000, 32'h00000080, 4'b0100);
    do_load(3'b001, 32'h202, 5'd9, 32'h80010000, 32'hFFFF8001, 4'b1100);
    do_load(3'b101, 32'h200, 5'd10, 32'h0000F00D, 32'h0000F00D, 4'b0011);
    do_load(3'b010, 32'h200, 5'd11, 32'h12345678, 32'h12345678, 4'b1111);

    // Misaligned / illegal accesses
    do_bad(OPL, 3'b010, 32'h301);
    do_bad(OPS, 3'b001, 32'h001);
    do_bad(OPL, 3'b011, 32'h000);

    // Load timeout: 16 WAIT cycles then bus_err, late rvalid ignored
    in_valid = 1'b1; opcode = OPL; func3 = 3'b010; rd_data = 32'h400; rd_num = 5'd12; wb_reg = 1'b1;
    cyc(); in_valid = 1'b0; dmem_gnt = 1'b1;
    #2; chk("to_req", 32'(dmem_req), 32'd1);
    cyc(); dmem_gnt = 1'b0;
    for (int i = 1; i < 16; i++) begin
      #2; chk("to_wait_stall", 32'(stall), 32'd1); chk("to_wait_buserr", 32'(bus_err), 32'd0);
      cyc();
    end
    #2; chk("to_last_stall", 32'(stall), 32'd0); chk("to_last_buserr", 32'(bus_err), 32'd0);
    cyc(); dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #2; chk("to_buserr", 32'(bus_err), 32'd1); chk("to_idle_stall", 32'(stall), 32'd0);
    chk("to_idle_req", 32'(dmem_req), 32'd0); chk("to_rfwe", 32'(rf_we), 32'd0);
    cyc(); dmem_rvalid = 1'b0;
    #2; chk("to_late_rfwe", 32'(rf_we), 32'd0); chk("to_buserr_end", 32'(bus_err), 32'd0);

    // Asynchronous reset while in REQ
    cyc(); in_valid = 1'b1; opcode = OPS; func3 = 3'b010; rd_data = 32'h500; rs2_data = 32'h1;
    cyc(); in_valid = 1'b0;
    #2; chk("rr_req", 32'(dmem_req), 32'd1); chk("rr_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1; chk("rr_req0", 32'(dmem_req), 32'd0); chk("rr_stall0", 32'(stall), 32'd0);
    chk("rr_rfwe0", 32'(rf_we), 32'd0); chk("rr_addr0", dmem_addr, 32'd0);
    cyc(); rst_n = 1'b1;
    cyc(); in_valid = 1'b1; opcode = OPR; wb_reg = 1'b1; rd_num = 5'd3; rd_data = 32'hCAFE;
    cyc(); in_valid = 1'b0;
    #2; chk("rr_alu_we", 32'(rf_we), 32'd1); chk("rr_alu_num", 32'(rf_wr_num), 32'd3);
    chk("rr_alu_data", rf_wr_data, 32'hCAFE); chk("rr_alu_req", 32'(dmem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
